// File: rtl/ret_stack.sv
// Return-address stack: CALL in EX pushes ex_pc+1, RET in EX pops; the top is read combinationally.
// Define RET_STACK_ERR_EN to build the sticky overflow/underflow flags; without it both outputs are 0.

`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module ret_stack #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ex_instr,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_valid,
    input  logic              stall,
    output logic [PC_W-1:0]   ret_addr,
    output logic              ret_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    logic [PC_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] sp_reg, sp_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W-1:0] top_idx;
    logic [3:0]        opcode;
    logic              act, is_call, is_ret, full, empty, push, pop;
    logic              unused_instr_bits;

    assign opcode            = ex_instr[15:12];
    assign unused_instr_bits = ^ex_instr[11:0];

    assign act     = ex_valid & ~stall;
    assign is_call = (opcode == `CALL);
    assign is_ret  = (opcode == `RET);
    assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push    = act & is_call;
    assign pop     = act & is_ret & ~empty;

    // A push while full lands on sp, which is exactly the oldest entry.
    always_comb begin
        sp_next    = sp_reg;
        count_next = count_reg;
        if (push) begin
            sp_next = sp_reg + ADDR_W'(1);
            if (!full) begin
                count_next = count_reg + (ADDR_W+1)'(1);
            end
        end else if (pop) begin
            sp_next    = sp_reg - ADDR_W'(1);
            count_next = count_reg - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg    <= '0;
            count_reg <= '0;
        end else begin
            sp_reg    <= sp_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[sp_reg] <= ex_pc + PC_W'(1);
        end
    end

    // Top of stack is visible in the same cycle a RET sits in EX.
    assign top_idx   = sp_reg - ADDR_W'(1);
    assign ret_addr  = empty ? '0 : mem[top_idx];
    assign ret_valid = ~empty;
    assign count     = count_reg;

`ifdef RET_STACK_ERR_EN
    logic overflow_reg, underflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_reg <= 1'b1;
            end
            if (act && is_ret && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: reset, call/return, nesting, PC wrap, overflow, qualifiers,
// underflow and mid-stack reset.

`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module tb_ret_stack;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_LW  = 4'h1;
    localparam logic [3:0] OP_B   = 4'h8;

`ifdef RET_STACK_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ex_instr;
    logic [15:0] ex_pc;
    logic        ex_valid;
    logic        stall;
    logic [15:0] ret_addr;
    logic        ret_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    ret_stack #(.DEPTH(8), .ADDR_W(3), .PC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_instr  (ex_instr),
        .ex_pc     (ex_pc),
        .ex_valid  (ex_valid),
        .stall     (stall),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one edge, then return EX to a bubble.
    task automatic issue(input logic [3:0] op, input logic [15:0] pc, input logic vld, input logic stl);
        ex_instr = {op, 12'h000};
        ex_pc    = pc;
        ex_valid = vld;
        stall    = stl;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic do_call(input logic [15:0] pc);
        issue(`CALL, pc, 1'b1, 1'b0);
    endtask

    // Checks the pre-pop top during the RET cycle, then lets the pop happen.
    task automatic do_ret(input string tag, input logic [15:0] exp_top);
        ex_instr = {`RET, 12'h000};
        ex_pc    = 16'h0000;
        ex_valid = 1'b1;
        stall    = 1'b0;
        #1;
        chk(tag, 32'(ret_addr), 32'(exp_top));
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_instr = '0; ex_pc = '0; ex_valid = 1'b0; stall = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(ret_valid), 32'd0);
        chk("rst_addr", 32'(ret_addr), 32'h0000);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);

        // Single call/return
        do_call(16'hC0DA);
        chk("call_valid", 32'(ret_valid), 32'd1);
        chk("call_addr", 32'(ret_addr), 32'hC0DB);
        chk("call_count", 32'(count), 32'd1);
        do_ret("ret_top", 16'hC0DB);
        chk("ret_count", 32'(count), 32'd0);
        chk("ret_addr0", 32'(ret_addr), 32'h0000);

        // Nesting
        do_call(16'h0100);
        do_call(16'h0200);
        do_call(16'h0300);
        chk("nest_count", 32'(count), 32'd3);
        do_ret("nest_ret1", 16'h0301);
        do_ret("nest_ret2", 16'h0201);
        do_ret("nest_ret3", 16'h0101);
        chk("nest_empty", 32'(count), 32'd0);

        // PC wrap
        do_call(16'hFFFF);
        chk("wrap_addr", 32'(ret_addr), 32'h0000);
        chk("wrap_valid", 32'(ret_valid), 32'd1);
        do_ret("wrap_ret", 16'h0000);
        chk("wrap_empty", 32'(count), 32'd0);

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) begin
            do_call(16'h0010 + 16'(i));
        end
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_addr", 32'(ret_addr), 32'h0019);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EXP));
        for (int i = 0; i < 8; i++) begin
            do_ret($sformatf("ovf_ret%0d", i), 16'h0019 - 16'(i));
        end
        chk("ovf_empty", 32'(count), 32'd0);
        chk("ovf_nvalid", 32'(ret_valid), 32'd0);
        chk("ovf_udf0", 32'(underflow), 32'd0);

        // Stall: one push when stall drops
        ex_instr = {`CALL, 12'h000}; ex_pc = 16'h0500; ex_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_cnt%0d", i), 32'(count), 32'd0);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("stall_count", 32'(count), 32'd1);
        chk("stall_addr", 32'(ret_addr), 32'h0501);

        // Bubble CALL and non-stack opcodes leave state alone
        issue(`CALL, 16'h0700, 1'b0, 1'b0);
        chk("bubble_cnt", 32'(count), 32'd1);
        issue(OP_ADD, 16'h0800, 1'b1, 1'b0);
        issue(OP_LW, 16'h0801, 1'b1, 1'b0);
        issue(OP_B, 16'h0802, 1'b1, 1'b0);
        chk("other_count", 32'(count), 32'd1);
        chk("other_addr", 32'(ret_addr), 32'h0501);
        do_ret("stall_ret", 16'h0501);

        // Underflow
        do_ret("udf_top", 16'h0000);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_addr", 32'(ret_addr), 32'h0000);
        chk("udf_flag", 32'(underflow), 32'(ERR_EXP));

        // Reset with entries present
        do_call(16'h0A00);
        do_call(16'h0B00);
        do_call(16'h0C00);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(ret_valid), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        chk("mrst_udf", 32'(underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
